// File: rtl/npu_fifo_bridge_pkg.sv
// ---------------------------------------------------------------------------
// npu_fifo_bridge_pkg
// Shared definitions for the NPU FIFO bridge slice:
//   NPU_DATA_W      default word width of all three FIFOs
//   NPU_*_DEPTH     default FIFO depths (powers of two)
//   ptr_w()         FIFO pointer / occupancy width for a given depth
//                   (log2(depth)+1; the extra MSB separates full from empty)
// ---------------------------------------------------------------------------
package npu_fifo_bridge_pkg;

    localparam int NPU_DATA_W     = 32;
    localparam int NPU_CFG_DEPTH  = 8;
    localparam int NPU_DIN_DEPTH  = 16;
    localparam int NPU_DOUT_DEPTH = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/npu_fifo_bridge_if.sv
// ---------------------------------------------------------------------------
// npu_fifo_bridge_if
// Bundles the CPU-side strobes, the NPU-core valid/ready channels and the
// occupancy observation outputs of the bridge.
//   slave  modport : seen by npu_fifo_bridge
//   master modport : seen by the pipeline / NPU core (or a testbench)
// CPU side   : iFlush, iNpuConfigWe/iNpuConfigFifo, iNpuDataWe/iNpuDataFifo,
//              iNpuDataRe, oNpuDataFifo, oNpuStall
// NPU side   : oCfgData/oCfgValid/iCfgReady, oInData/oInValid/iInReady,
//              iOutData/iOutValid/oOutReady
// Occupancy  : oCfgCount, oInCount, oOutCount (current number of entries)
// Optional   : NPU_FIFO_ERR_EN adds oErrOverflow, oErrUnderflow
// ---------------------------------------------------------------------------
interface npu_fifo_bridge_if
    import npu_fifo_bridge_pkg::*;
#(
    parameter int DATA_W     = NPU_DATA_W,
    parameter int CFG_DEPTH  = NPU_CFG_DEPTH,
    parameter int DIN_DEPTH  = NPU_DIN_DEPTH,
    parameter int DOUT_DEPTH = NPU_DOUT_DEPTH
);
    localparam int CFG_CW  = ptr_w(CFG_DEPTH);
    localparam int DIN_CW  = ptr_w(DIN_DEPTH);
    localparam int DOUT_CW = ptr_w(DOUT_DEPTH);

    // CPU execute-stage side
    logic              iFlush;
    logic              iNpuConfigWe;
    logic [DATA_W-1:0] iNpuConfigFifo;
    logic              iNpuDataWe;
    logic [DATA_W-1:0] iNpuDataFifo;
    logic              iNpuDataRe;
    logic [DATA_W-1:0] oNpuDataFifo;
    logic              oNpuStall;

    // NPU core side
    logic [DATA_W-1:0] oCfgData;
    logic              oCfgValid;
    logic              iCfgReady;
    logic [DATA_W-1:0] oInData;
    logic              oInValid;
    logic              iInReady;
    logic [DATA_W-1:0] iOutData;
    logic              iOutValid;
    logic              oOutReady;

    // Occupancy
    logic [CFG_CW-1:0]  oCfgCount;
    logic [DIN_CW-1:0]  oInCount;
    logic [DOUT_CW-1:0] oOutCount;

`ifdef NPU_FIFO_ERR_EN
    logic              oErrOverflow;
    logic              oErrUnderflow;
`endif

    modport slave (
        input  iFlush, iNpuConfigWe, iNpuConfigFifo, iNpuDataWe, iNpuDataFifo,
        input  iNpuDataRe, iCfgReady, iInReady, iOutData, iOutValid,
        output oNpuDataFifo, oNpuStall, oCfgData, oCfgValid, oInData, oInValid,
        output oOutReady, oCfgCount, oInCount, oOutCount
`ifdef NPU_FIFO_ERR_EN
        , output oErrOverflow, oErrUnderflow
`endif
    );

    modport master (
        output iFlush, iNpuConfigWe, iNpuConfigFifo, iNpuDataWe, iNpuDataFifo,
        output iNpuDataRe, iCfgReady, iInReady, iOutData, iOutValid,
        input  oNpuDataFifo, oNpuStall, oCfgData, oCfgValid, oInData, oInValid,
        input  oOutReady, oCfgCount, oInCount, oOutCount
`ifdef NPU_FIFO_ERR_EN
        , input oErrOverflow, oErrUnderflow
`endif
    );

endinterface

// File: rtl/npu_fifo_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// npu_sync_fifo
// Single-clock first-word-fall-through FIFO. A word pushed at edge N is on
// oHead right after edge N; pop consumes oHead at the edge.
// Ports:
//   iClk, iRst_n      clock, synchronous active-low reset
//   iFlush            synchronous clear, beats any same-cycle push/pop
//   iPush, iPushData  enqueue (ignored while oFull)
//   iPop              dequeue (ignored while oEmpty)
//   oHead             oldest entry (undefined content while empty)
//   oFull, oEmpty     registered status flags
//   oCount            number of stored entries (0..DEPTH)
// Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
// ---------------------------------------------------------------------------
module npu_sync_fifo
    import npu_fifo_bridge_pkg::*;
#(
    parameter int DATA_W = NPU_DATA_W,
    parameter int DEPTH  = NPU_CFG_DEPTH
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iFlush,
    input  logic                    iPush,
    input  logic [DATA_W-1:0]       iPushData,
    input  logic                    iPop,
    output logic [DATA_W-1:0]       oHead,
    output logic                    oFull,
    output logic                    oEmpty,
    output logic [ptr_w(DEPTH)-1:0] oCount
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Both sides are gated by last cycle's flags, so a pop at full frees the
    // slot only for the next cycle's push.
    assign push_ok = iPush & ~full_q;
    assign pop_ok  = iPop  & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        if (iFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        // Same index with differing wrap bits means the writer lapped the reader.
        full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge iClk) begin
        if (iRst_n && push_ok && !iFlush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= iPushData;
        end
    end

    // Asynchronous head read gives the fall-through behaviour.
    assign oHead  = mem_q[rd_ptr_q[AW-1:0]];
    assign oFull  = full_q;
    assign oEmpty = empty_q;
    assign oCount = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/npu_fifo_bridge.sv
// ---------------------------------------------------------------------------
// npu_fifo_bridge
// NPU-side endpoint of the execute-stage NPU interface. Buffers CPU config
// words and enqueued data for the NPU core, collects NPU results for the
// CPU to dequeue, and stalls the pipeline on write-while-full or
// read-while-empty.
// Ports:
//   iClk    clock
//   iRst_n  synchronous active-low reset
//   bus     npu_fifo_bridge_if.slave (CPU strobes, NPU valid/ready channels,
//           occupancy counts)
// Optional feature macro: NPU_FIFO_ERR_EN -- sticky oErrOverflow /
//   oErrUnderflow flags on the interface, cleared by reset or iFlush.
// ---------------------------------------------------------------------------
module npu_fifo_bridge
    import npu_fifo_bridge_pkg::*;
#(
    parameter int DATA_W     = NPU_DATA_W,
    parameter int CFG_DEPTH  = NPU_CFG_DEPTH,
    parameter int DIN_DEPTH  = NPU_DIN_DEPTH,
    parameter int DOUT_DEPTH = NPU_DOUT_DEPTH
) (
    input  logic             iClk,
    input  logic             iRst_n,
    npu_fifo_bridge_if.slave bus
);
    logic [DATA_W-1:0]           cfg_head, din_head, dout_head;
    logic                        cfg_full, din_full, dout_full;
    logic                        cfg_empty, din_empty, dout_empty;
    logic [ptr_w(CFG_DEPTH)-1:0] cfg_count;
    logic [ptr_w(DIN_DEPTH)-1:0] din_count;
    logic [ptr_w(DOUT_DEPTH)-1:0] dout_count;

    // CPU -> NPU config words
    npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iFlush    (bus.iFlush),
        .iPush     (bus.iNpuConfigWe),
        .iPushData (bus.iNpuConfigFifo),
        .iPop      (bus.iCfgReady),
        .oHead     (cfg_head),
        .oFull     (cfg_full),
        .oEmpty    (cfg_empty),
        .oCount    (cfg_count)
    );

    // CPU -> NPU data words
    npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DIN_DEPTH)) u_din_fifo (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iFlush    (bus.iFlush),
        .iPush     (bus.iNpuDataWe),
        .iPushData (bus.iNpuDataFifo),
        .iPop      (bus.iInReady),
        .oHead     (din_head),
        .oFull     (din_full),
        .oEmpty    (din_empty),
        .oCount    (din_count)
    );

    // NPU -> CPU results
    npu_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DOUT_DEPTH)) u_dout_fifo (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iFlush    (bus.iFlush),
        .iPush     (bus.iOutValid),
        .iPushData (bus.iOutData),
        .iPop      (bus.iNpuDataRe),
        .oHead     (dout_head),
        .oFull     (dout_full),
        .oEmpty    (dout_empty),
        .oCount    (dout_count)
    );

    // NPU core channels. Heads are masked while empty so stale storage never
    // shows on the buses.
    assign bus.oCfgData  = cfg_empty ? '0 : cfg_head;
    assign bus.oCfgValid = ~cfg_empty;
    assign bus.oInData   = din_empty ? '0 : din_head;
    assign bus.oInValid  = ~din_empty;
    assign bus.oOutReady = ~dout_full;

    // CPU dequeue port: combinational head, zero when nothing to read.
    assign bus.oNpuDataFifo = dout_empty ? '0 : dout_head;

    // The refused access is simply dropped; the pipeline holds and re-presents
    // the same strobe until the FIFO can take it.
    assign bus.oNpuStall = (bus.iNpuConfigWe & cfg_full) |
                           (bus.iNpuDataWe   & din_full) |
                           (bus.iNpuDataRe   & dout_empty);

    assign bus.oCfgCount = cfg_count;
    assign bus.oInCount  = din_count;
    assign bus.oOutCount = dout_count;

`ifdef NPU_FIFO_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    always_comb begin
        // Overflow covers the NPU result push too, not just CPU writes.
        err_ovf_d = err_ovf_q |
                    (bus.iNpuConfigWe & cfg_full) |
                    (bus.iNpuDataWe   & din_full) |
                    (bus.iOutValid    & dout_full);
        err_unf_d = err_unf_q | (bus.iNpuDataRe & dout_empty);
        if (bus.iFlush) begin
            err_ovf_d = 1'b0;
            err_unf_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign bus.oErrOverflow  = err_ovf_q;
    assign bus.oErrUnderflow = err_unf_q;
`endif

endmodule

// File: tb/tb_npu_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_npu_fifo_bridge
// Directed stimulus with a scoreboard: the stimulus process pushes the words
// it knows will be accepted into per-channel queues; a monitor pops and
// compares whenever a transfer is presented on a channel.
// Optional: NPU_FIFO_ERR_EN enables the sticky error-flag test.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_npu_fifo_bridge;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    npu_fifo_bridge_if bus ();

    npu_fifo_bridge dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] cfg_exp[$];
    logic [31:0] din_exp[$];
    logic [31:0] dout_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Monitor: transfers complete at the next rising edge with the values
    // visible at the falling edge.
    always @(negedge iClk) begin : monitor
        logic [31:0] e;
        if (iRst_n) begin
            if (bus.oCfgValid && bus.iCfgReady) begin
                if (cfg_exp.size() == 0) begin
                    check("cfg_spurious_xfer", bus.oCfgValid, 1'b0);
                end else begin
                    e = cfg_exp.pop_front();
                    check("cfg_order", bus.oCfgData, e);
                    $display("[TB] cfg  xfer 0x%08h exp 0x%08h", bus.oCfgData, e);
                end
            end
            if (bus.oInValid && bus.iInReady) begin
                if (din_exp.size() == 0) begin
                    check("din_spurious_xfer", bus.oInValid, 1'b0);
                end else begin
                    e = din_exp.pop_front();
                    check("din_order", bus.oInData, e);
                    $display("[TB] din  xfer 0x%08h exp 0x%08h", bus.oInData, e);
                end
            end
            if (bus.iNpuDataRe) begin
                if (dout_exp.size() == 0) begin
                    check("dout_empty_data", bus.oNpuDataFifo, 32'h0);
                    check("dout_empty_stall", bus.oNpuStall, 1'b1);
                    $display("[TB] dout read on empty, data 0x%08h", bus.oNpuDataFifo);
                end else begin
                    e = dout_exp.pop_front();
                    check("dout_order", bus.oNpuDataFifo, e);
                    $display("[TB] dout xfer 0x%08h exp 0x%08h", bus.oNpuDataFifo, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int next;
        int guard;
        bus.iFlush = 0; bus.iNpuConfigWe = 0; bus.iNpuConfigFifo = 0;
        bus.iNpuDataWe = 0; bus.iNpuDataFifo = 0; bus.iNpuDataRe = 0;
        bus.iCfgReady = 0; bus.iInReady = 0; bus.iOutData = 0; bus.iOutValid = 0;

        // ---- 1: reset ----
        iRst_n = 0;
        repeat (2) @(posedge iClk);
        #1 iRst_n = 1;
        @(negedge iClk);
        check("rst_cfg_valid", bus.oCfgValid, 0);
        check("rst_in_valid", bus.oInValid, 0);
        check("rst_out_ready", bus.oOutReady, 1);
        check("rst_dout_data", bus.oNpuDataFifo, 0);
        check("rst_stall", bus.oNpuStall, 0);
        check("rst_cfg_count", bus.oCfgCount, 0);

        // ---- 2: config FIFO fill, full stall, drain ----
        for (int i = 1; i <= 8; i++) begin
            step();
            bus.iNpuConfigWe = 1;
            bus.iNpuConfigFifo = 32'hA5A5_0000 + i;
            @(negedge iClk);
            check("cfg_fill_stall", bus.oNpuStall, 0);
            cfg_exp.push_back(32'hA5A5_0000 + i);
        end
        step();
        bus.iNpuConfigFifo = 32'hA5A5_0009;
        @(negedge iClk);
        check("cfg_full_stall", bus.oNpuStall, 1);
        check("cfg_full_count", bus.oCfgCount, 8);
        check("cfg_full_valid", bus.oCfgValid, 1);
        step();
        bus.iCfgReady = 1;
        @(negedge iClk);
        check("cfg_full_pop_stall", bus.oNpuStall, 1);
        step();
        @(negedge iClk);
        check("cfg_after_pop_stall", bus.oNpuStall, 0);
        check("cfg_after_pop_count", bus.oCfgCount, 7);
        cfg_exp.push_back(32'hA5A5_0009);
        step();
        bus.iNpuConfigWe = 0;
        guard = 0;
        while (bus.oCfgValid && guard < 20) begin step(); guard++; end
        @(negedge iClk);
        check("cfg_drained_valid", bus.oCfgValid, 0);
        check("cfg_drained_count", bus.oCfgCount, 0);
        bus.iCfgReady = 0;

        // ---- 3: dequeue on empty output FIFO ----
        step();
        bus.iNpuDataRe = 1;
        bus.iOutValid = 1;
        bus.iOutData = 32'hDEAD_BEEF;
        @(negedge iClk);
        check("dout_re_empty_stall", bus.oNpuStall, 1);
        check("dout_re_empty_data", bus.oNpuDataFifo, 0);
        step();
        bus.iOutValid = 0;
        dout_exp.push_back(32'hDEAD_BEEF);
        @(negedge iClk);
        check("dout_hit_stall", bus.oNpuStall, 0);
        check("dout_hit_data", bus.oNpuDataFifo, 32'hDEAD_BEEF);
        step();
        bus.iNpuDataRe = 0;
        @(negedge iClk);
        check("dout_popped_data", bus.oNpuDataFifo, 0);
        check("dout_popped_count", bus.oOutCount, 0);

        // ---- 4: data-in FIFO at full, push+pop, 40-word stream ----
        for (int i = 0; i < 16; i++) begin
            step();
            bus.iNpuDataWe = 1;
            bus.iNpuDataFifo = 32'hD000_0000 + i;
            @(negedge iClk);
            check("din_fill_stall", bus.oNpuStall, 0);
            din_exp.push_back(32'hD000_0000 + i);
        end
        step();
        bus.iNpuDataFifo = 32'hD000_0010;
        bus.iInReady = 1;
        @(negedge iClk);
        check("din_full_count", bus.oInCount, 16);
        check("din_full_pop_stall", bus.oNpuStall, 1);
        step();
        bus.iInReady = 0;
        @(negedge iClk);
        check("din_after_pop_stall", bus.oNpuStall, 0);
        check("din_after_pop_count", bus.oInCount, 15);
        din_exp.push_back(32'hD000_0010);
        step();
        bus.iNpuDataWe = 0;
        @(negedge iClk);
        check("din_refill_count", bus.oInCount, 16);
        next = 17;
        guard = 0;
        bus.iInReady = 1;
        while (next < 40 && guard < 200) begin
            step();
            bus.iNpuDataWe = 1;
            bus.iNpuDataFifo = 32'hD000_0000 + next;
            @(negedge iClk);
            if (!bus.oNpuStall) begin
                din_exp.push_back(32'hD000_0000 + next);
                next++;
            end
            guard++;
        end
        check("din_stream_done", next, 40);
        step();
        bus.iNpuDataWe = 0;
        guard = 0;
        while (bus.oInValid && guard < 40) begin step(); guard++; end
        @(negedge iClk);
        check("din_drained_count", bus.oInCount, 0);
        bus.iInReady = 0;

        // ---- 5: flush with FIFOs half full and same-cycle pushes ----
        for (int i = 0; i < 8; i++) begin
            step();
            bus.iNpuConfigWe = (i < 4);
            bus.iNpuConfigFifo = 32'hC000_0000 + i;
            bus.iNpuDataWe = 1;
            bus.iNpuDataFifo = 32'hB000_0000 + i;
            bus.iOutValid = 1;
            bus.iOutData = 32'h9000_0000 + i;
        end
        step();
        bus.iFlush = 1;
        bus.iNpuConfigWe = 1;
        bus.iNpuDataWe = 1;
        bus.iOutValid = 1;
        @(negedge iClk);
        check("flush_pre_cfg_count", bus.oCfgCount, 4);
        check("flush_pre_in_count", bus.oInCount, 8);
        check("flush_pre_out_count", bus.oOutCount, 8);
        step();
        bus.iFlush = 0;
        bus.iNpuConfigWe = 0;
        bus.iNpuDataWe = 0;
        bus.iOutValid = 0;
        @(negedge iClk);
        check("flush_cfg_count", bus.oCfgCount, 0);
        check("flush_in_count", bus.oInCount, 0);
        check("flush_out_count", bus.oOutCount, 0);
        check("flush_cfg_valid", bus.oCfgValid, 0);
        check("flush_in_valid", bus.oInValid, 0);
        check("flush_out_ready", bus.oOutReady, 1);
        check("flush_dout_data", bus.oNpuDataFifo, 0);

`ifdef NPU_FIFO_ERR_EN
        // ---- 6: sticky error flags ----
        check("err_ovf_clear", bus.oErrOverflow, 0);
        check("err_unf_clear", bus.oErrUnderflow, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            bus.iNpuConfigWe = 1;
            bus.iNpuConfigFifo = 32'hE000_0000 + i;
        end
        step();
        @(negedge iClk);
        check("err_full_stall", bus.oNpuStall, 1);
        step();
        bus.iNpuConfigWe = 0;
        @(negedge iClk);
        check("err_ovf_set", bus.oErrOverflow, 1);
        check("err_unf_still_clear", bus.oErrUnderflow, 0);
        step();
        bus.iNpuDataRe = 1;
        step();
        bus.iNpuDataRe = 0;
        @(negedge iClk);
        check("err_unf_set", bus.oErrUnderflow, 1);
        check("err_ovf_sticky", bus.oErrOverflow, 1);
        step();
        bus.iFlush = 1;
        step();
        bus.iFlush = 0;
        @(negedge iClk);
        check("err_ovf_flushed", bus.oErrOverflow, 0);
        check("err_unf_flushed", bus.oErrUnderflow, 0);
`endif

        repeat (2) step();
        check("cfg_leftover", cfg_exp.size(), 0);
        check("din_leftover", din_exp.size(), 0);
        check("dout_leftover", dout_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
